// File: rtl/branch_unit.sv
`default_nettype none
// ============================================================================
// Module   : branch_unit
// Brief    : PC register with two-cycle register-operand branch resolution;
//            link stack (JAL/RET) built only when BRANCH_LINK_STACK_EN is set.
// Revision : 1.0
// ============================================================================
module branch_unit #(
  parameter int PC_W        = 8,
  parameter int DATA_W      = 8,
  parameter int RA_W        = 3,
  parameter int RESET_PC    = 0,
  parameter int STACK_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [15:0]       instr,
  input  logic              instr_valid,
  output logic              instr_ready,
  output logic [RA_W-1:0]   rf_raddr1,
  output logic [RA_W-1:0]   rf_raddr2,
  input  logic [DATA_W-1:0] rf_rdata1,
  input  logic [DATA_W-1:0] rf_rdata2,
  output logic [PC_W-1:0]   pc,
  output logic              taken,
  output logic              flush,
  output logic              stack_err
);

  localparam logic [0:0] c_st_run     = 1'b0;
  localparam logic [0:0] c_st_resolve = 1'b1;

  localparam logic [4:0] c_op_bne  = 5'b10011;
  localparam logic [4:0] c_op_be   = 5'b10100;
  localparam logic [4:0] c_op_bner = 5'b10101;
  localparam logic [4:0] c_op_ber  = 5'b10110;
  localparam logic [4:0] c_op_j    = 5'b10111;
  localparam logic [4:0] c_op_jr   = 5'b11000;

  localparam logic [PC_W-1:0] c_reset_pc = PC_W'(RESET_PC);

  logic [0:0]      r_state, w_state_nxt;
  logic [4:0]      r_op;
  logic [PC_W-1:0] r_m;
  logic [RA_W-1:0] r_r1, r_r2;
  logic [PC_W-1:0] r_pc;
  logic            r_taken;

  logic [4:0]      w_op;
  logic [PC_W-1:0] w_m, w_pc_inc;
  logic [RA_W-1:0] w_r1, w_r2;
  logic            w_accept, w_is_branch, w_a_zero;
  logic            w_jump, w_res_taken;
  logic [PC_W-1:0] w_jump_pc, w_res_pc;

  assign w_op     = instr[15:11];
  assign w_m      = PC_W'(instr[7:0]);
  assign w_r1     = instr[8 +: RA_W];
  assign w_r2     = instr[0 +: RA_W];
  assign w_accept = instr_valid && (r_state == c_st_run);
  assign w_pc_inc = r_pc + PC_W'(1);
  assign w_a_zero = (rf_rdata1 == '0);

  assign w_is_branch = (w_op == c_op_bne) || (w_op == c_op_be) || (w_op == c_op_bner) ||
                       (w_op == c_op_ber) || (w_op == c_op_jr);

`ifdef BRANCH_LINK_STACK_EN
  localparam logic [4:0] c_op_jal = 5'b11001;
  localparam logic [4:0] c_op_ret = 5'b11010;
  localparam int c_sp_w  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int c_cnt_w = $clog2(STACK_DEPTH + 1);
  localparam logic [c_sp_w-1:0]  c_sp_last  = c_sp_w'(STACK_DEPTH - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_full = c_cnt_w'(STACK_DEPTH);

  logic [PC_W-1:0]    r_stack [STACK_DEPTH];
  logic [c_sp_w-1:0]  r_wp, w_wp_inc, w_wp_dec;
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_stack_err, w_push, w_pop, w_empty;
  logic [PC_W-1:0]    w_pop_pc;

  assign w_push   = w_accept && (w_op == c_op_jal);
  assign w_pop    = w_accept && (w_op == c_op_ret);
  assign w_empty  = (r_cnt == '0);
  assign w_wp_inc = (r_wp == c_sp_last) ? '0 : r_wp + c_sp_w'(1);
  assign w_wp_dec = (r_wp == '0) ? c_sp_last : r_wp - c_sp_w'(1);
  assign w_pop_pc = w_empty ? c_reset_pc : r_stack[w_wp_dec];

  always_ff @(posedge clk) begin
    if (w_push) r_stack[r_wp] <= w_pc_inc;
  end

  // Full pushes wrap over the oldest entry; the count saturates at depth.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wp        <= '0;
      r_cnt       <= '0;
      r_stack_err <= 1'b0;
    end else if (w_push) begin
      r_wp <= w_wp_inc;
      if (r_cnt == c_cnt_full) r_stack_err <= 1'b1;
      else                     r_cnt       <= r_cnt + c_cnt_w'(1);
    end else if (w_pop) begin
      if (w_empty) begin
        r_stack_err <= 1'b1;
      end else begin
        r_wp  <= w_wp_dec;
        r_cnt <= r_cnt - c_cnt_w'(1);
      end
    end
  end

  assign stack_err = r_stack_err;
`else
  assign stack_err = 1'b0;
`endif

  // Single-cycle redirects taken straight from RUN.
  always_comb begin
    w_jump    = (w_op == c_op_j);
    w_jump_pc = w_m;
`ifdef BRANCH_LINK_STACK_EN
    if (w_op == c_op_jal) begin
      w_jump = 1'b1;
    end else if (w_op == c_op_ret) begin
      w_jump    = 1'b1;
      w_jump_pc = w_pop_pc;
    end
`endif
  end

  always_comb begin
    w_res_taken = 1'b0;
    w_res_pc    = r_m;
    case (r_op)
      c_op_bne:  w_res_taken = !w_a_zero;
      c_op_be:   w_res_taken = w_a_zero;
      c_op_bner: begin w_res_taken = !w_a_zero; w_res_pc = PC_W'(rf_rdata2); end
      c_op_ber:  begin w_res_taken = w_a_zero;  w_res_pc = PC_W'(rf_rdata2); end
      c_op_jr:   begin w_res_taken = 1'b1;      w_res_pc = PC_W'(rf_rdata1); end
      default:   ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= c_st_run;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_run:     if (w_accept && w_is_branch) w_state_nxt = c_st_resolve;
      c_st_resolve: w_state_nxt = c_st_run;
      default:      w_state_nxt = c_st_run;
    endcase
  end

  always_comb begin
    instr_ready = (r_state == c_st_run);
    rf_raddr1   = w_r1;
    rf_raddr2   = w_r2;
    if (r_state == c_st_resolve) begin
      rf_raddr1 = r_r1;
      rf_raddr2 = r_r2;
    end
  end

  // pc is frozen during RESOLVE, so w_pc_inc is still the acceptance pc + 1.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pc    <= c_reset_pc;
      r_taken <= 1'b0;
      r_op    <= '0;
      r_m     <= '0;
      r_r1    <= '0;
      r_r2    <= '0;
    end else begin
      r_taken <= 1'b0;
      if (r_state == c_st_resolve) begin
        r_pc    <= w_res_taken ? w_res_pc : w_pc_inc;
        r_taken <= w_res_taken;
      end else if (w_accept) begin
        if (w_jump) begin
          r_pc    <= w_jump_pc;
          r_taken <= 1'b1;
        end else if (w_is_branch) begin
          r_op <= w_op;
          r_m  <= w_m;
          r_r1 <= w_r1;
          r_r2 <= w_r2;
        end else begin
          r_pc <= w_pc_inc;
        end
      end
    end
  end

  assign pc    = r_pc;
  assign taken = r_taken;
  assign flush = r_taken;

endmodule
`default_nettype wire

// File: tb/tb_branch_unit.sv
`default_nettype none
// Bench for branch_unit: directed and random instruction streams scored
// against a behavioural PC/branch/link-stack model through an expect queue.
module tb_branch_unit;

  localparam int RESET_PC = 0;
  localparam int DEPTH    = 4;

  localparam logic [4:0] NOP  = 5'b00000;
  localparam logic [4:0] BNE  = 5'b10011;
  localparam logic [4:0] BE   = 5'b10100;
  localparam logic [4:0] BNER = 5'b10101;
  localparam logic [4:0] BER  = 5'b10110;
  localparam logic [4:0] J    = 5'b10111;
  localparam logic [4:0] JR   = 5'b11000;
  localparam logic [4:0] JAL  = 5'b11001;
  localparam logic [4:0] RET  = 5'b11010;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] instr = '0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [2:0]  rf_raddr1, rf_raddr2;
  logic [7:0]  rf_rdata1 = '0, rf_rdata2 = '0;
  logic [7:0]  pc;
  logic        taken, flush, stack_err;

  branch_unit #(.PC_W(8), .DATA_W(8), .RA_W(3), .RESET_PC(RESET_PC), .STACK_DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2), .pc(pc), .taken(taken),
    .flush(flush), .stack_err(stack_err)
  );

  always #5 clk = ~clk;

  // Register file with a synchronous read port.
  logic [7:0] rf [8];
  always @(posedge clk) begin
    rf_rdata1 <= rf[rf_raddr1];
    rf_rdata2 <= rf[rf_raddr2];
  end

  typedef struct {
    logic [7:0] pc;
    logic       tk;
    logic       err;
    int         lat;
    logic [2:0] ra1;
  } exp_t;

  exp_t       q[$];
  exp_t       cur;
  logic [7:0] mpc = 8'(RESET_PC);
  logic       merr = 1'b0;
  logic [7:0] mstk[$];
  int         pass_cnt = 0;
  int         tot_cnt = 0;
  int         wcnt = 0;
  logic [7:0] hold = 8'(RESET_PC);
  logic       mon_en = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    tot_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  function automatic logic [15:0] enc(input logic [4:0] op, input logic [2:0] r1, input logic [7:0] lo);
    return {op, r1, lo};
  endfunction

  // Reference model: the architectural effect of one accepted instruction.
  task automatic model(input logic [15:0] ins);
    exp_t e;
    logic [7:0] m, a, b, inc;
    m   = ins[7:0];
    a   = rf[ins[10:8]];
    b   = rf[ins[2:0]];
    inc = mpc + 8'd1;
    e.lat = 1; e.tk = 1'b0; e.pc = inc; e.ra1 = ins[10:8];
    case (ins[15:11])
      J:    begin e.tk = 1'b1; e.pc = m; end
      BNE:  begin e.lat = 2; if (a != 0) begin e.tk = 1'b1; e.pc = m; end end
      BE:   begin e.lat = 2; if (a == 0) begin e.tk = 1'b1; e.pc = m; end end
      BNER: begin e.lat = 2; if (a != 0) begin e.tk = 1'b1; e.pc = b; end end
      BER:  begin e.lat = 2; if (a == 0) begin e.tk = 1'b1; e.pc = b; end end
      JR:   begin e.lat = 2; e.tk = 1'b1; e.pc = a; end
`ifdef BRANCH_LINK_STACK_EN
      JAL: begin
        mstk.push_back(inc);
        if (mstk.size() > DEPTH) begin void'(mstk.pop_front()); merr = 1'b1; end
        e.tk = 1'b1; e.pc = m;
      end
      RET: begin
        e.tk = 1'b1;
        if (mstk.size() == 0) begin e.pc = 8'(RESET_PC); merr = 1'b1; end
        else e.pc = mstk.pop_back();
      end
`endif
      default: ;
    endcase
    e.err = merr;
    mpc   = e.pc;
    q.push_back(e);
  endtask

  task automatic send(input logic [15:0] ins);
    int n;
    @(negedge clk);
    model(ins);
    instr = ins;
    instr_valid = 1'b1;
    n = 0;
    #2;
    while (!instr_ready && n < 20) begin @(negedge clk); #2; n++; end
    if (n >= 20) chk("accept timeout", int'(instr_ready), 1);
    @(posedge clk);
    #1 instr_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0 || wcnt != 0) && n < 50) begin @(negedge clk); n++; end
    chk("drain queue", q.size(), 0);
    @(negedge clk);
  endtask

  // Monitor: pops one expectation per observed handshake and checks the
  // resolve cycle and completion; between completions taken must stay low.
  always @(negedge clk) begin
    #1;
    if (!mon_en) begin
      wcnt = 0;
      hold = 8'(RESET_PC);
    end else begin
      if (wcnt > 0) begin
        wcnt--;
        if (wcnt == 0) begin
          chk("pc", int'(pc), int'(cur.pc));
          chk("taken", int'(taken), int'(cur.tk));
          chk("flush", int'(flush), int'(cur.tk));
          chk("stack_err", int'(stack_err), int'(cur.err));
          hold = cur.pc;
        end else begin
          chk("resolve instr_ready", int'(instr_ready), 0);
          chk("resolve rf_raddr1", int'(rf_raddr1), int'(cur.ra1));
          chk("resolve taken", int'(taken), 0);
        end
      end else begin
        chk("idle taken", int'(taken | flush), 0);
        chk("idle pc", int'(pc), int'(hold));
      end
      if (instr_valid && instr_ready) begin
        if (q.size() == 0) chk("unexpected accept", 1, 0);
        else begin cur = q.pop_front(); wcnt = cur.lat; end
      end
    end
  end

  task automatic rand_phase(input int cnt);
    logic [4:0] op;
    for (int i = 0; i < cnt; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      rf[$urandom_range(0, 7)] = ($urandom_range(0, 1) != 0) ? 8'h00 : 8'($urandom);
      case ($urandom_range(0, 9))
        0: op = NOP;  1: op = 5'($urandom); 2: op = J;   3: op = BNE; 4: op = BE;
        5: op = BNER; 6: op = BER;          7: op = JR;  8: op = JAL; default: op = RET;
      endcase
      send(enc(op, 3'($urandom), 8'($urandom)));
    end
  endtask

  initial begin
    foreach (rf[i]) rf[i] = 8'h00;
    repeat (2) @(negedge clk);
    #1;
    chk("reset pc", int'(pc), RESET_PC);
    chk("reset taken", int'(taken), 0);
    chk("reset flush", int'(flush), 0);
    chk("reset instr_ready", int'(instr_ready), 1);
    chk("reset stack_err", int'(stack_err), 0);
    reset_n = 1'b1;
    mon_en  = 1'b1;

    repeat (3) send(enc(NOP, 3'd0, 8'h00));
    repeat (3) @(negedge clk);
    repeat (2) send(enc(NOP, 3'd1, 8'h12));
    send(enc(J, 3'd0, 8'h40));
    rf[3] = 8'h00; send(enc(BNE, 3'd3, 8'h20));
    rf[3] = 8'h07; send(enc(BNE, 3'd3, 8'h20));
    rf[1] = 8'h00; rf[2] = 8'h9A; send(enc(BER, 3'd1, 8'h02));
    rf[4] = 8'h11; send(enc(JR, 3'd4, 8'h00));
    rf[6] = 8'h55; send(enc(BNER, 3'd6, 8'h02));
    send(enc(BE, 3'd6, 8'h33));
    send(enc(BE, 3'd1, 8'h9C));
    send(enc(J, 3'd0, 8'hFF));
    send(enc(NOP, 3'd0, 8'h00));
    send(enc(BE, 3'd1, 8'h01));
`ifdef BRANCH_LINK_STACK_EN
    send(enc(J, 3'd0, 8'h10));
    send(enc(JAL, 3'd0, 8'h30));
    send(enc(RET, 3'd0, 8'h00));
    for (int i = 0; i < 5; i++) send(enc(JAL, 3'd0, 8'(8'h50 + 8'(i * 16))));
    for (int i = 0; i < 5; i++) send(enc(RET, 3'd0, 8'h00));
`endif
    rand_phase(150);
    drain();

    // Reset while a BE is resolving: no redirect may follow release.
    mon_en = 1'b0;
    @(negedge clk);
    rf[5] = 8'h00;
    instr = enc(BE, 3'd5, 8'h77);
    instr_valid = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("pre-reset resolve ready", int'(instr_ready), 0);
    reset_n = 1'b0;
    #1;
    chk("async reset pc", int'(pc), RESET_PC);
    chk("async reset instr_ready", int'(instr_ready), 1);
    chk("async reset taken", int'(taken | flush), 0);
    chk("async reset stack_err", int'(stack_err), 0);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      #1;
      chk("post-reset taken", int'(taken), 0);
      chk("post-reset pc", int'(pc), RESET_PC);
    end
    mpc  = 8'(RESET_PC);
    merr = 1'b0;
    mstk.delete();
    q.delete();
    #1 mon_en = 1'b1;

    rand_phase(60);
    drain();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
`default_nettype wire
